// File: rtl/rv32i_single_cycle_core_if.sv
// Memory-side bus of the single-cycle RV32I core.
// The core drives the fetch address and the data-memory request through the
// master modport; the instruction and data memories answer combinationally
// through the slave modport.
interface rv32i_single_cycle_core_if;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        memwrite;
  logic [31:0] aluout;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        halt;

  modport master (
    output pc,
    output memwrite,
    output aluout,
    output writedata,
    output halt,
    input  instr,
    input  readdata
  );

  modport slave (
    input  pc,
    input  memwrite,
    input  aluout,
    input  writedata,
    input  halt,
    output instr,
    output readdata
  );
endinterface

// File: rtl/rv32i_single_cycle_core.sv
// Single-cycle RV32I integer core: PC register, decoder, immediate generator,
// 32x32 register file and ALU. Every instruction retires in one clock.
// Optional feature macro: PC_TRACE_EN -- when defined, prints the PC on every
// non-halted rising edge and ends simulation when a SYSTEM instruction is hit.
module rv32i_single_cycle_core (
  input  logic                       clk,
  input  logic                       reset,
  rv32i_single_cycle_core_if.master  bus
);

  localparam int WORD = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'd0,
    SRCB_IMM  = 2'd1,
    SRCB_FOUR = 2'd2
  } srcb_sel_e;

  // Arithmetic op selection shared by R-type and I-type ALU instructions.
  // alt is instr[30]; SUB exists only for register-register forms.
  function automatic alu_op_e arith_ctl(input logic [2:0] f3, input logic alt,
                                        input logic allow_sub);
    case (f3)
      3'b000:  return (alt && allow_sub) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  logic [WORD-1:0] r_pc;
  logic [WORD-1:0] r_regs [32];

  logic [6:0]      w_op;
  logic [4:0]      w_rd;
  logic [2:0]      w_funct3;
  logic [4:0]      w_rs1_addr;
  logic [4:0]      w_rs2_addr;
  logic [WORD-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [WORD-1:0] w_rs1_val, w_rs2_val;

  logic            w_regwrite;
  logic            w_memwrite;
  logic            w_memtoreg;
  logic            w_srca_pc;
  srcb_sel_e       w_srcb_sel;
  logic [WORD-1:0] w_imm;
  alu_op_e         w_alu_ctl;
  logic            w_branch;
  logic            w_br_inv;
  logic            w_jal;
  logic            w_jalr;
  logic            w_lui;
  logic            w_halt;

  logic [WORD-1:0] w_src_a, w_src_b;
  logic [WORD-1:0] w_alu_result;
  logic            w_zero;
  logic            w_taken;
  logic [WORD-1:0] w_wb_data;
  logic [WORD-1:0] w_pc_plus4, w_branch_target, w_jal_sum, w_jalr_sum;
  logic [WORD-1:0] w_pc_next;

  assign w_op       = bus.instr[6:0];
  assign w_rd       = bus.instr[11:7];
  assign w_funct3   = bus.instr[14:12];
  assign w_rs2_addr = bus.instr[24:20];
  // LUI reuses the ADD path as 0 + immU, so its rs1 port is pinned to x0.
  assign w_rs1_addr = w_lui ? 5'd0 : bus.instr[19:15];

  assign w_imm_i = {{20{bus.instr[31]}}, bus.instr[31:20]};
  assign w_imm_s = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
  assign w_imm_b = {{19{bus.instr[31]}}, bus.instr[31], bus.instr[7],
                    bus.instr[30:25], bus.instr[11:8], 1'b0};
  assign w_imm_u = {bus.instr[31:12], 12'b0};
  assign w_imm_j = {{11{bus.instr[31]}}, bus.instr[31], bus.instr[19:12],
                    bus.instr[20], bus.instr[30:21], 1'b0};

  // x0 is hardwired to zero on both read ports.
  assign w_rs1_val = (w_rs1_addr == 5'd0) ? '0 : r_regs[w_rs1_addr];
  assign w_rs2_val = (w_rs2_addr == 5'd0) ? '0 : r_regs[w_rs2_addr];

  // Main decoder: all controls default to a harmless NOP, each opcode overrides.
  always_comb begin
    w_regwrite = 1'b0;
    w_memwrite = 1'b0;
    w_memtoreg = 1'b0;
    w_srca_pc  = 1'b0;
    w_srcb_sel = SRCB_RS2;
    w_imm      = w_imm_i;
    w_alu_ctl  = ALU_ADD;
    w_branch   = 1'b0;
    w_br_inv   = 1'b0;
    w_jal      = 1'b0;
    w_jalr     = 1'b0;
    w_lui      = 1'b0;
    w_halt     = 1'b0;
    case (w_op)
      OP_R: begin
        w_regwrite = 1'b1;
        w_alu_ctl  = arith_ctl(w_funct3, bus.instr[30], 1'b1);
      end
      OP_IALU: begin
        w_regwrite = 1'b1;
        w_srcb_sel = SRCB_IMM;
        w_alu_ctl  = arith_ctl(w_funct3, bus.instr[30], 1'b0);
      end
      OP_LOAD: begin
        w_regwrite = 1'b1;
        w_memtoreg = 1'b1;
        w_srcb_sel = SRCB_IMM;
      end
      OP_STORE: begin
        w_memwrite = 1'b1;
        w_srcb_sel = SRCB_IMM;
        w_imm      = w_imm_s;
      end
      OP_BRANCH: begin
        w_branch = 1'b1;
        case (w_funct3)
          3'b000: begin w_alu_ctl = ALU_SUB;  w_br_inv = 1'b0; end
          3'b001: begin w_alu_ctl = ALU_SUB;  w_br_inv = 1'b1; end
          3'b100: begin w_alu_ctl = ALU_SLT;  w_br_inv = 1'b1; end
          3'b101: begin w_alu_ctl = ALU_SLT;  w_br_inv = 1'b0; end
          3'b110: begin w_alu_ctl = ALU_SLTU; w_br_inv = 1'b1; end
          3'b111: begin w_alu_ctl = ALU_SLTU; w_br_inv = 1'b0; end
          default: w_branch = 1'b0;  // undefined funct3 never branches
        endcase
      end
      OP_LUI: begin
        w_regwrite = 1'b1;
        w_lui      = 1'b1;
        w_srcb_sel = SRCB_IMM;
        w_imm      = w_imm_u;
      end
      OP_AUIPC: begin
        w_regwrite = 1'b1;
        w_srca_pc  = 1'b1;
        w_srcb_sel = SRCB_IMM;
        w_imm      = w_imm_u;
      end
      OP_JAL: begin
        w_regwrite = 1'b1;
        w_jal      = 1'b1;
        w_srca_pc  = 1'b1;
        w_srcb_sel = SRCB_FOUR;
      end
      OP_JALR: begin
        w_regwrite = 1'b1;
        w_jalr     = 1'b1;
        w_srca_pc  = 1'b1;
        w_srcb_sel = SRCB_FOUR;
      end
      OP_SYSTEM: w_halt = 1'b1;
      default: ;
    endcase
  end

  assign w_src_a = w_srca_pc ? r_pc : w_rs1_val;

  // Operand B mux: register, immediate, or the link-address constant 4.
  always_comb begin
    w_src_b = w_rs2_val;
    case (w_srcb_sel)
      SRCB_IMM:  w_src_b = w_imm;
      SRCB_FOUR: w_src_b = 32'd4;
      default:   w_src_b = w_rs2_val;
    endcase
  end

  // ALU: shift amount is operand B's low five bits; unused codes yield 0.
  always_comb begin
    w_alu_result = '0;
    case (w_alu_ctl)
      ALU_ADD:  w_alu_result = w_src_a + w_src_b;
      ALU_SUB:  w_alu_result = w_src_a - w_src_b;
      ALU_SLL:  w_alu_result = w_src_a << w_src_b[4:0];
      ALU_SLT:  w_alu_result = {31'b0, $signed(w_src_a) < $signed(w_src_b)};
      ALU_SLTU: w_alu_result = {31'b0, w_src_a < w_src_b};
      ALU_XOR:  w_alu_result = w_src_a ^ w_src_b;
      ALU_SRL:  w_alu_result = w_src_a >> w_src_b[4:0];
      ALU_SRA:  w_alu_result = $unsigned($signed(w_src_a) >>> w_src_b[4:0]);
      ALU_OR:   w_alu_result = w_src_a | w_src_b;
      ALU_AND:  w_alu_result = w_src_a & w_src_b;
      default:  w_alu_result = '0;
    endcase
  end

  assign w_zero    = (w_alu_result == '0);
  assign w_taken   = w_branch & (w_zero ^ w_br_inv);
  assign w_wb_data = w_memtoreg ? bus.readdata : w_alu_result;

  // Jump/branch targets use dedicated adders because the ALU is busy
  // producing the link address (JAL/JALR) or the comparison (branches).
  assign w_pc_plus4      = r_pc + 32'd4;
  assign w_branch_target = r_pc + w_imm_b;
  assign w_jal_sum       = r_pc + w_imm_j;
  assign w_jalr_sum      = w_rs1_val + w_imm_i;

  // Next-PC priority: halt freezes, then jumps, then taken branch, else +4.
  always_comb begin
    w_pc_next = w_pc_plus4;
    if (w_halt)       w_pc_next = r_pc;
    else if (w_jal)   w_pc_next = {w_jal_sum[31:1], 1'b0};
    else if (w_jalr)  w_pc_next = {w_jalr_sum[31:1], 1'b0};
    else if (w_taken) w_pc_next = w_branch_target;
  end

  // PC register; reset forces fetch address 0 immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_pc <= '0;
    else       r_pc <= w_pc_next;
  end

  // Register file write port; contents survive reset, but an edge seen while
  // reset is high discards the write of the interrupted instruction.
  always_ff @(posedge clk) begin
    if (!reset && w_regwrite && (w_rd != 5'd0)) r_regs[w_rd] <= w_wb_data;
  end

  assign bus.pc        = r_pc;
  assign bus.memwrite  = w_memwrite;
  assign bus.aluout    = w_alu_result;
  assign bus.writedata = w_rs2_val;
  assign bus.halt      = w_halt;

`ifdef PC_TRACE_EN
  // Simulation trace: report each executed PC, stop when SYSTEM is reached.
  always @(posedge clk) begin
    if (w_halt) $finish;
    else        $display("PC = %0d", r_pc);
  end
`endif

endmodule

// File: tb/tb_rv32i_single_cycle_core.sv
// Directed bench for rv32i_single_cycle_core: the stimulus process drives one
// instruction per cycle and queues the hand-computed bus response; the monitor
// pops and compares at each falling edge (or on demand for async reset).
module tb_rv32i_single_cycle_core;

  logic clk;
  logic reset;

  rv32i_single_cycle_core_if bus ();

  rv32i_single_cycle_core dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic        mw;
    logic        halt;
    logic        chk_alu;
    logic [31:0] alu;
    logic        chk_wd;
    logic [31:0] wd;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  event mon_ev;

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                        input int rd, input logic [6:0] op);
    logic [31:0] v;
    v = imm;
    return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                        input int f3, input int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
    logic [31:0] v;
    v = imm;
    return {v[11:5], 5'(rs2), 5'(rs1), 3'b010, v[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1,
                                        input int f3);
    logic [31:0] v;
    v = imm;
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_u(input int imm20, input int rd, input logic [6:0] op);
    logic [31:0] v;
    v = imm20;
    return {v[19:0], 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input int rd);
    logic [31:0] v;
    v = imm;
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'b1101111};
  endfunction

  task automatic push_exp(input string name, input logic [31:0] pc, input logic mw,
                          input logic halt, input logic chk_alu, input logic [31:0] alu,
                          input logic chk_wd, input logic [31:0] wd);
    exp_t e;
    e.name = name; e.pc = pc; e.mw = mw; e.halt = halt;
    e.chk_alu = chk_alu; e.alu = alu; e.chk_wd = chk_wd; e.wd = wd;
    exp_q.push_back(e);
  endtask

  // Present one instruction for a full cycle and queue its expected response.
  task automatic issue(input logic [31:0] ins, input logic [31:0] rdata, input string name,
                       input logic [31:0] pc, input logic mw, input logic halt,
                       input logic chk_alu, input logic [31:0] alu,
                       input logic chk_wd, input logic [31:0] wd);
    bus.instr    = ins;
    bus.readdata = rdata;
    push_exp(name, pc, mw, halt, chk_alu, alu, chk_wd, wd);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s.%s: got %08h expected %08h", name, field, act, exp);
  endtask

  // Monitor: compare the DUT bus against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or mon_ev);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check(e.name, "pc", bus.pc, e.pc);
        check(e.name, "memwrite", {31'b0, bus.memwrite}, {31'b0, e.mw});
        check(e.name, "halt", {31'b0, bus.halt}, {31'b0, e.halt});
        if (e.chk_alu) check(e.name, "aluout", bus.aluout, e.alu);
        if (e.chk_wd)  check(e.name, "writedata", bus.writedata, e.wd);
        $display("txn %-10s pc=%08h aluout=%08h writedata=%08h memwrite=%0b halt=%0b",
                 e.name, bus.pc, bus.aluout, bus.writedata, bus.memwrite, bus.halt);
      end
    end
  end

  initial begin
    reset        = 1'b1;
    bus.instr    = NOP;
    bus.readdata = '0;
    @(posedge clk);
    #1;
    issue(NOP, 0, "rst_hold0", 32'h0, 0, 0, 0, 0, 0, 0);
    issue(NOP, 0, "rst_hold1", 32'h0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;

    issue(enc_i(5, 0, 0, 1, 7'b0010011), 0, "addi_x1", 32'h00, 0, 0, 1, 32'd5, 0, 0);
    issue(enc_i(-3, 0, 0, 2, 7'b0010011), 0, "addi_x2", 32'h04, 0, 0, 1, 32'hFFFF_FFFD, 0, 0);
    issue(enc_r(0, 2, 1, 0, 3), 0, "add_x3", 32'h08, 0, 0, 1, 32'd2, 0, 0);
    issue(enc_r(32, 2, 1, 0, 4), 0, "sub_x4", 32'h0C, 0, 0, 1, 32'd8, 0, 0);
    issue(enc_s(12, 4, 0), 0, "sw_x4", 32'h10, 1, 0, 1, 32'd12, 1, 32'd8);
    issue(enc_i(-16, 0, 0, 5, 7'b0010011), 0, "addi_x5", 32'h14, 0, 0, 1, 32'hFFFF_FFF0, 0, 0);
    issue(enc_i(32'h402, 5, 5, 6, 7'b0010011), 0, "srai_x6", 32'h18, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    issue(enc_s(8, 1, 0), 0, "sw_x1", 32'h1C, 1, 0, 1, 32'd8, 1, 32'd5);
    issue(enc_b(16, 1, 1, 0), 0, "beq", 32'h20, 0, 0, 1, 32'd0, 0, 0);
    issue(enc_i(8, 0, 2, 5, 7'b0000011), 32'd5, "lw_x5", 32'h30, 0, 0, 1, 32'd8, 0, 0);
    issue(enc_s(0, 5, 0), 0, "sw_x5", 32'h34, 1, 0, 1, 32'd0, 1, 32'd5);
    issue(enc_b(16, 1, 1, 1), 0, "bne", 32'h38, 0, 0, 1, 32'd0, 0, 0);
    issue(enc_i(-1, 0, 0, 8, 7'b0010011), 0, "addi_x8", 32'h3C, 0, 0, 1, 32'hFFFF_FFFF, 0, 0);
    issue(enc_i(1, 0, 0, 9, 7'b0010011), 0, "addi_x9", 32'h40, 0, 0, 1, 32'd1, 0, 0);
    issue(enc_b(8, 9, 8, 4), 0, "blt", 32'h44, 0, 0, 1, 32'd1, 0, 0);
    issue(enc_b(8, 9, 8, 6), 0, "bltu", 32'h4C, 0, 0, 1, 32'd0, 0, 0);
    issue(enc_j(8, 1), 0, "jal", 32'h50, 0, 0, 1, 32'h54, 0, 0);
    issue(enc_s(0, 1, 0), 0, "sw_link", 32'h58, 1, 0, 1, 32'd0, 1, 32'h54);
    issue(enc_i(1, 1, 0, 0, 7'b1100111), 0, "jalr", 32'h5C, 0, 0, 1, 32'h60, 0, 0);
    issue(enc_u(32'h12345, 6, 7'b0110111), 0, "lui", 32'h54, 0, 0, 1, 32'h1234_5000, 0, 0);
    issue(enc_u(1, 10, 7'b0010111), 0, "auipc", 32'h58, 0, 0, 1, 32'h0000_1058, 0, 0);
    issue(enc_s(0, 6, 0), 0, "sw_x6", 32'h5C, 1, 0, 1, 32'd0, 1, 32'h1234_5000);
    issue(enc_i(11, 0, 0, 7, 7'b0010011), 0, "addi_x7", 32'h60, 0, 0, 1, 32'd11, 0, 0);

    // Reset lands in the middle of an ADDI x7 that must not retire.
    bus.instr = enc_i(99, 0, 0, 7, 7'b0010011);
    push_exp("addi_x7b", 32'h64, 0, 0, 1, 32'd99, 0, 0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    push_exp("rst_async", 32'h0, 0, 0, 0, 0, 0, 0);
    ->mon_ev;
    @(posedge clk);
    #1;
    reset = 1'b0;

    issue(enc_s(0, 7, 0), 0, "sw_x7", 32'h00, 1, 0, 1, 32'd0, 1, 32'd11);
    issue(enc_i(0, 0, 0, 7, 7'b1110011), 0, "sys0", 32'h04, 0, 1, 0, 0, 0, 0);
    issue(enc_i(0, 0, 0, 7, 7'b1110011), 0, "sys1", 32'h04, 0, 1, 0, 0, 0, 0);
    issue(enc_i(0, 0, 0, 7, 7'b1110011), 0, "sys2", 32'h04, 0, 1, 0, 0, 0, 0);

    reset = 1'b1;
    issue(NOP, 0, "rst_again", 32'h0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    issue(enc_s(0, 7, 0), 0, "sw_x7_post", 32'h00, 1, 0, 1, 32'd0, 1, 32'd11);
    issue(NOP, 0, "nop_next", 32'h04, 0, 0, 0, 0, 0, 0);

    @(posedge clk);
    #1;
    total_cnt++;
    if (exp_q.size() == 0) pass_cnt++;
    else $display("FAIL drain: got %0d pending expected 0", exp_q.size());

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/rv32i_single_cycle_core.md
# rv32i_single_cycle_core

Single-cycle RV32I integer core: PC register, instruction decoder, immediate generator, 32×32 register file and ALU. It sits between an external instruction memory, addressed by `pc` and returning `instr` combinationally, and an external data memory, addressed by `aluout`, which takes `writedata`/`memwrite` and returns `readdata` combinationally. Every instruction completes in one clock.

## Interface
- No parameters; datapath width fixed at `WORD` = 32.
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- pc  output  32  current program counter
- instr  input  32  instruction at `pc`
- memwrite  output  1  data-memory write enable (store)
- aluout  output  32  ALU result / data address
- writedata  output  32  rs2 value (store data)
- readdata  input  32  data-memory read value
- halt  output  1  current instruction is SYSTEM (opcode 1110011)

## Operation
- Field slices: op=instr[6:0], rd=[11:7], funct3=[14:12], rs1=[19:15], rs2=[24:20], funct7=[31:25].
- Immediate, sign-extended from instr[31]:
  - I: [31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - U: {[31:12],12'b0}.
  - J: {[31],[19:12],[20],[30:21],0}.
- ALU ops (4-bit control): 0 ADD, 1 SUB, 2 SLL, 3 SLT (signed), 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND; others give 0. Shift amount = b[4:0]. zero = (result==0).
- ALU operands:
  - srcA: rs1 value, or `pc` for AUIPC/JAL/JALR.
  - srcB: rs2 value, imm, or constant 4 for JAL/JALR.
- Register-file write data: `readdata` for loads, else `aluout`.
- Decode by opcode:
  - R (0110011): rd = rs1 op rs2. funct7[5] selects SUB over ADD and SRA over SRL.
  - I-ALU (0010011): rd = rs1 op imm. funct7[5] selects SRAI over SRLI.
  - LW (0000011): aluout = rs1+imm; rd = readdata.
  - SW (0100011): aluout = rs1+imm; memwrite=1; no register write.
  - Branch (1100011): BEQ/BNE use SUB. BLT/BGE use SLT. BLTU/BGEU use SLTU. Inversion is applied for BNE, BLT and BLTU. Taken = zero XOR inversion; target = pc+immB.
  - LUI (0110111): rs1 read port forced to x0; aluout = 0+immU.
  - AUIPC (0010111): aluout = pc+immU.
  - JAL (1101111): rd = pc+4; next pc = (pc+immJ)&~1.
  - JALR (1100111): rd = pc+4; next pc = (rs1+immI)&~1. Target computed from the pre-write rs1 value.
  - SYSTEM (1110011): halt=1; no register or memory write; PC holds.
  - Any other opcode: NOP (no writes, pc+4).
- Next PC: jump target, else taken-branch target, else pc+4.
- Register file:
  - Two combinational read ports and one write port, written on the clk rising edge when regwrite is set.
  - x0 always reads 0 and writes to it are discarded.
  - Register contents are not cleared by reset.

## Timing
- One instruction per cycle.
- `pc` and register writes update on the rising edge of clk.
- `memwrite`, `aluout`, `writedata` and `halt` are combinational from `instr`, `pc` and register state.
- reset asserted: pc=0 immediately, asynchronously, and holds while asserted. After deassertion, first fetch is at 0.
- Reset asserted mid-instruction: pc goes to 0 immediately and the pending register write is suppressed.
- While halt=1, pc and state are frozen until reset.
- Back-to-back dependencies are resolved without stalls, because register reads are combinational.

## Configuration
- `PC_TRACE_EN` defined: each rising clk edge with halt=0 prints `PC = <decimal pc>` via $display. When halt=1 the simulation ends with $finish.
- `PC_TRACE_EN` undefined:
  - no simulation-only constructs are compiled;
  - halt affects behaviour only through the `halt` output and the frozen PC.

## Test plan
- Reset mid-run: assert reset at an arbitrary point -> pc=0 immediately, no register written; after release, program restarts at 0.
- ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2; SUB x4,x1,x2 -> x3=2, x4=8. Then SRA with rs1=-16 and shift 2 -> -4.
- SW x1,8(x0) -> memwrite=1, aluout=8, writedata=5. LW x5,8(x0) with readdata=5 -> x5=5, memwrite=0.
- BEQ x1,x1,+16 at pc=0x20 -> next pc=0x30.
  - BNE x1,x1,+16 -> next pc=0x24.
  - BLT with -1 vs 1 -> taken.
  - BLTU with -1 vs 1 -> not taken.
- JAL x1,+8 at pc=0x40 -> x1=0x44, pc=0x48.
  - JALR x0,1(x1) -> pc=0x44, low bit cleared.
  - LUI x6,0x12345 -> 0x12345000.
  - AUIPC at pc=0x100 with imm 1 -> 0x1100.
- SYSTEM opcode at pc=0x50 -> halt=1, pc stays 0x50 on subsequent edges, no register or memory writes.
